// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_pkg : shared types, defaults and helpers for the feeder     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package conv_pkg;

  localparam int N_DEF      = 7;
  localparam int STRIDE_DEF = 5;
  localparam int IM_DEF     = 28;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } feeder_state_t;

  function automatic int pad_of(input int stride);
    return (stride - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_ram : image store, one sync write port, registered read    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pixel_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rd_data;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/conv_pixel_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_pixel_feeder : streams a zero-padded image to full_conv     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module conv_pixel_feeder
  import conv_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int IM     = IM_DEF,
  parameter int IMG    = IM + (STRIDE - 1)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr_en,
  input  logic [11:0]  i_wr_addr,
  input  logic [N:0]   i_wr_data,
  output logic         o_wr_ready,
  input  logic         i_start,
  input  logic         i_data_request,
  output logic [N:0]   o_data,
  output logic         o_data_valid,
  input  logic         i_conv_fin,
  output logic         o_busy,
  output logic         o_done
);

  localparam int PAD    = pad_of(STRIDE);
  localparam int DEPTH  = IM * IM;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(IMG + 1);

  localparam logic [CW-1:0]     C_LAST  = CW'(IMG - 1);
  localparam logic [CW-1:0]     C_LO    = CW'(PAD);
  localparam logic [CW-1:0]     C_HI    = CW'(PAD + IM);
  localparam logic [11:0]       C_DEPTH = 12'(DEPTH);
  localparam logic [RAM_AW-1:0] C_IM    = RAM_AW'(IM);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_STREAM = ST_STREAM;
  localparam logic [1:0] S_DONE   = ST_DONE;

  if (IMG * IMG > 4096) begin : g_size_check
    $error("conv_pixel_feeder: padded frame exceeds 4096 pixels");
  end

  logic [1:0]        r_state;
  logic [CW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic              r_all;
  logic              r_valid;
  logic              r_pad;
  logic              w_honour;
  logic              w_inwin;
  logic              w_wr;
  logic [CW-1:0]     w_row_off;
  logic [CW-1:0]     w_col_off;
  logic [RAM_AW-1:0] w_rd_idx;
  logic [N:0]        w_ram_q;

  assign w_inwin   = (r_row >= C_LO) && (r_row < C_HI) &&
                     (r_col >= C_LO) && (r_col < C_HI);
  assign w_row_off = r_row - C_LO;
  assign w_col_off = r_col - C_LO;
  assign w_rd_idx  = RAM_AW'(w_row_off) * C_IM + RAM_AW'(w_col_off);

  // r_all marks the last pixel as issued; STREAM then lingers one cycle so
  // done lands after the final data_valid pulse.
  assign w_honour = (r_state == S_STREAM) && i_data_request && !i_conv_fin && !r_all;
  assign w_wr     = (r_state == S_IDLE) && i_wr_en && (i_wr_addr < C_DEPTH);

  pixel_ram #(
    .WIDTH (N + 1),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr),
    .i_wr_addr (i_wr_addr[RAM_AW-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (w_honour && w_inwin),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_all   <= 1'b0;
      r_valid <= 1'b0;
      r_pad   <= 1'b1;
    end else begin
      r_valid <= w_honour;
      if (w_honour) begin
        r_pad <= !w_inwin;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_STREAM;
            r_row   <= '0;
            r_col   <= '0;
            r_all   <= 1'b0;
          end
        end
        S_STREAM: begin
          if (i_conv_fin || r_all) begin
            r_state <= S_DONE;
          end else if (w_honour) begin
            if (r_col == C_LAST) begin
              r_col <= '0;
              if (r_row == C_LAST) begin
                r_all <= 1'b1;
              end else begin
                r_row <= r_row + CW'(1);
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Both the pad flag and the RAM register only move on an honoured request,
  // so data holds between pulses.
  assign o_data       = r_pad ? '0 : w_ram_q;
  assign o_data_valid = r_valid;
  assign o_wr_ready   = (r_state == S_IDLE);
  assign o_busy       = (r_state == S_STREAM);
  assign o_done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_pixel_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_conv_pixel_feeder : directed self-checking bench              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_conv_pixel_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;
  logic        req = 1'b0;
  logic        fin = 1'b0;
  logic        wr_ready;
  logic [7:0]  data;
  logic        valid;
  logic        busy;
  logic        done;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  conv_pixel_feeder dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_wr_data      (wr_data),
    .o_wr_ready     (wr_ready),
    .i_start        (start),
    .i_data_request (req),
    .o_data         (data),
    .o_data_valid   (valid),
    .i_conv_fin     (fin),
    .o_busy         (busy),
    .o_done         (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Padded 32x32 frame over a 28x28 image holding mem[k] = k[7:0].
  function automatic logic [7:0] exp_pix(input int p);
    int r;
    int c;
    r = p / 32;
    c = p % 32;
    if (r < 2 || r >= 30 || c < 2 || c >= 30) return 8'd0;
    return 8'((r - 2) * 28 + (c - 2));
  endfunction

  // stop_at = 0 runs the full frame; otherwise stop after stop_at pulses
  // with conv_fin (by_fin) or with a reset.
  task automatic run_frame(input int stop_at, input bit by_fin, input bit disturb);
    int cnt;
    bit prev;
    bit done_seen;
    cnt = 0;
    prev = 1'b0;
    done_seen = 1'b0;
    req = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 1200; cyc++) begin
      step();
      if (disturb) begin
        wr_en   = (cyc >= 10 && cyc < 14);
        wr_addr = 12'd0;
        wr_data = 8'hFF;
        start   = (cyc == 20);
        if (cyc == 12) chk("wr_ready_in_stream", wr_ready, 0);
      end
      if (done) begin
        chk("done_after_last_pulse", prev, 1);
        chk("frame_pulse_count", cnt, 1024);
        chk("valid_low_at_done", valid, 0);
        done_seen = 1'b1;
        break;
      end
      if (valid) begin
        if (cnt > 0) chk($sformatf("no_bubble_%0d", cnt), prev, 1);
        chk($sformatf("pix_%0d", cnt), data, exp_pix(cnt));
        cnt++;
      end
      prev = valid;
      if (stop_at > 0 && cnt == stop_at) break;
    end
    wr_en = 1'b0;
    start = 1'b0;
    if (stop_at == 0) begin
      chk("frame_done_seen", done_seen, 1);
      req = 1'b0;
      step();
      chk("done_one_cycle", done, 0);
      chk("idle_wr_ready", wr_ready, 1);
    end else if (by_fin) begin
      chk("fin_reached_pixel", cnt, stop_at);
      fin = 1'b1;
      step();
      fin = 1'b0;
      req = 1'b0;
      chk("fin_drops_request", valid, 0);
      chk("fin_done", done, 1);
      step();
      chk("fin_done_one_cycle", done, 0);
      chk("fin_idle_wr_ready", wr_ready, 1);
      chk("fin_idle_busy", busy, 0);
    end else begin
      chk("rst_reached_pixel", cnt, stop_at);
      reset = 1'b0;
      step();
      chk("rst_valid_dropped", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_data", data, 0);
      reset = 1'b1;
      step();
      chk("rst_idle_ignores_req", valid, 0);
      req = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    reset = 1'b0;
    step();
    step();
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_ready", wr_ready, 1);
    reset = 1'b1;
    step();

    // Image load, plus an out-of-range write that would alias mem[0]
    for (int k = 0; k < 784; k++) begin
      wr_en   = 1'b1;
      wr_addr = 12'(k);
      wr_data = 8'(k);
      step();
    end
    wr_addr = 12'd1024;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;

    // Requests in IDLE without start are ignored
    req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_no_valid", valid, 0);
      chk("idle_wr_ready", wr_ready, 1);
      chk("idle_busy", busy, 0);
    end
    req = 1'b0;
    step();

    // Full frame with request held high
    run_frame(0, 1'b0, 1'b0);

    // Sparse requests, one every three cycles
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      chk($sformatf("sparse_pre_%0d", i), valid, 0);
      req = 1'b1;
      step();
      req = 1'b0;
      chk($sformatf("sparse_valid_%0d", i), valid, 1);
      chk($sformatf("sparse_pix_%0d", i), data, exp_pix(i));
      step();
      chk($sformatf("sparse_single_%0d", i), valid, 0);
      chk($sformatf("sparse_done_%0d", i), done, (i == 1023) ? 1 : 0);
      step();
    end
    chk("sparse_idle_after", wr_ready, 1);

    // conv_fin together with the request for pixel 500
    run_frame(500, 1'b1, 1'b0);

    // Reset mid-frame at pixel 300, then restream with memory retained
    run_frame(300, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);

    // Writes and start during STREAM are ignored
    run_frame(0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_pixel_feeder.md
# conv_pixel_feeder

Pixel source that answers the `data_request` / `data_valid` handshake of `full_conv`. It holds one `im`×`im` 8-bit image loaded through a simple write port. On each request it streams the zero-padded `img`×`img` frame, in raster order, one pixel per request. It sits directly in front of `full_conv`, replaces the bench-side feeder, and stops when the convolution reports `conv_fin`.

## Interface
- `N`, 7, pixel MSB index (pixel width N+1).
- `stride`, 5, kernel side length; padding `PAD` = (stride-1)/2 on each side.
- `im`, 28, unpadded image side.
- `img`, im + (stride-1), padded frame side streamed to the consumer.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  image write strobe.
- `wr_addr`  in  12  linear address, row*im + col, in the unpadded image.
- `wr_data`  in  N+1  pixel written.
- `wr_ready`  out  1  writes accepted; high only in IDLE.
- `start`  in  1  one-cycle pulse that begins a frame.
- `data_request`  in  1  consumer asks for the next pixel.
- `data`  out  N+1  pixel value.
- `data_valid`  out  1  `data` is the requested pixel this cycle.
- `conv_fin`  in  1  consumer finished; abort streaming.
- `busy`  out  1  high in STREAM.
- `done`  out  1  one-cycle pulse when the frame ends (complete or aborted).

## Operation
- States: IDLE, STREAM, DONE.
- IDLE:
  - `wr_ready`=1.
  - `wr_en` writes `wr_data` to `mem[wr_addr]`. Addresses ≥ im*im are ignored.
  - `start` clears the row/col counters and moves to STREAM. `data_request` is ignored.
- STREAM:
  - A request in cycle t is honoured when the pixel count is < img*img. The honoured pixel is at counters (row,col).
  - If `row<PAD`, `row≥PAD+im`, `col<PAD` or `col≥PAD+im`, the output is 0. Otherwise it is `mem[(row-PAD)*im + (col-PAD)]`.
  - col increments per honoured request. At img-1 it wraps to 0 and row increments.
  - After pixel img*img-1 is honoured, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `conv_fin`=1 in STREAM moves to DONE next cycle. No further `data_valid` is produced, and any request in that same cycle is dropped.
- `start` outside IDLE: ignored. `wr_en` outside IDLE: ignored (`wr_ready`=0).
- Back-to-back requests: one pixel per cycle, no bubbles.
- Address arithmetic uses a 12-bit index with no wrap. img*img ≤ 4096 is required; elaborate-time assertion.

## Timing
- Latency: request sampled at edge t gives `data_valid`=1 and the pixel on `data` during cycle t+1.
- `data_valid` is a single-cycle pulse per honoured request.
- `data` holds its last value when `data_valid`=0.
- `done` asserts the cycle after the final `data_valid` pulse, or the cycle after `conv_fin` is sampled.
- Reset values: state IDLE, row=col=0, `data`=0, `data_valid`=0, `busy`=0, `done`=0, `wr_ready`=1 (after reset edge).
- Reset mid-STREAM: return to IDLE on the next edge and drop any pending `data_valid`. Image memory contents are retained and not cleared.
- Memory read is registered. The pad decision is registered alongside it so that `data` and `data_valid` align.

## Structure
- Package `conv_pkg`:
  - state enum typedef `feeder_state_t`;
  - function `pad_of(stride)`;
  - shared localparam defaults N=7, stride=5, im=28.
- Sub-module `pixel_ram`: im*im × (N+1), one synchronous write port and one registered read port. Maps to block RAM.
- The top level holds the FSM, row/col counters, pad-window compare, and handshake regs.

## Test plan
All scenarios use N=7, stride=5, im=28 (PAD=2, img=32), with `mem[k]=k[7:0]` loaded in IDLE.
1. Reset then idle. Hold `data_request`=1 without `start` → `data_valid` stays 0, `wr_ready`=1, `busy`=0.
2. Full frame, request held high:
   - exactly 1024 `data_valid` pulses on consecutive cycles;
   - pulse 0 gives 0; pulse 66 (row2,col2) gives 0 (mem[0]); pulse 67 gives 1; pulse 93 (row2,col29) gives 27; pulse 94 (col30) gives 0 (pad);
   - `done` pulses on the cycle after pulse 1023.
3. Sparse requests, one every 3 cycles → each `data_valid` appears exactly 1 cycle after its request; pixel sequence identical to scenario 2.
4. `conv_fin` asserted together with the request for pixel 500 → no `data_valid` for pixel 500 or later; `done` next cycle; then IDLE with `wr_ready`=1.
5. Reset low at pixel 300:
   - no `data_valid` after the reset edge; state IDLE;
   - a new `start` restreams from pixel 0, and pixel 67 is still 1 (memory retained).
6. Write attempts during STREAM (`wr_addr`=0, `wr_data`=0xFF) are ignored: the next frame's pixel 66 is still 0. A `start` during STREAM does not reset the counters.
